// File: rtl/i2c_master_arbiter.sv
// Round-robin arbiter that lends one i2c_master to NUM_REQ local requesters,
// one single-register transaction at a time, with start/transfer timeouts.
module i2c_master_arbiter #(
  parameter int NUM_REQ       = 4,
  parameter int START_TIMEOUT = 64,
  parameter int XFER_TIMEOUT  = 65535
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NUM_REQ-1:0]    req,
  input  logic [NUM_REQ-1:0]    req_rw,
  input  logic [7*NUM_REQ-1:0]  req_chip_addr,
  input  logic [8*NUM_REQ-1:0]  req_reg_addr,
  input  logic [16*NUM_REQ-1:0] req_wdata,
  output logic [NUM_REQ-1:0]    gnt,
  output logic [NUM_REQ-1:0]    rsp_valid,
  output logic [15:0]           rsp_rdata,
  output logic [3:0]            rsp_status,
  output logic [6:0]            m_chip_addr,
  output logic [7:0]            m_reg_addr,
  output logic [15:0]           m_data_in,
  output logic                  m_write_en,
  output logic                  m_read_en,
  input  logic                  m_busy,
  input  logic [3:0]            m_status,
  input  logic [15:0]           m_data_out
);
  localparam int IW   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int TMAX = (START_TIMEOUT > XFER_TIMEOUT) ? START_TIMEOUT : XFER_TIMEOUT;
  localparam int TW   = $clog2(TMAX + 1);

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT_START, WAIT_DONE, RESP} state_t;

  typedef struct packed {
    logic        rw;
    logic [6:0]  chip;
    logic [7:0]  regad;
    logic [15:0] wdata;
  } xfer_t;

  state_t          state, next_state;
  xfer_t           pick_x, cur_x;
  logic [IW-1:0]   last_grant, cur_idx, pick, idx;
  logic            pick_vld;
  logic [TW-1:0]   timer;
  logic            start_to, xfer_to;
  logic            busy_q;
  logic [3:0]      status_q;
  logic [15:0]     dout_q;

  // Master outputs are registered once so busy/status/data are seen together.
  always_ff @(posedge clk) begin
    if (!reset) begin
      busy_q   <= 1'b0;
      status_q <= 4'h0;
      dout_q   <= 16'h0;
    end else begin
      busy_q   <= m_busy;
      status_q <= m_status;
      dout_q   <= m_data_out;
    end
  end

  // Scan from last_grant+1 with wrap-around; the first set request wins.
  always_comb begin
    pick     = '0;
    pick_vld = 1'b0;
    idx      = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = IW'((int'(last_grant) + k) % NUM_REQ);
      if (!pick_vld && req[idx]) begin
        pick     = idx;
        pick_vld = 1'b1;
      end
    end
  end

  always_comb begin
    pick_x       = '0;
    pick_x.rw    = req_rw[pick];
    pick_x.chip  = req_chip_addr[7*int'(pick) +: 7];
    pick_x.regad = req_reg_addr[8*int'(pick) +: 8];
    pick_x.wdata = req_wdata[16*int'(pick) +: 16];
  end

  assign start_to = (timer == TW'(START_TIMEOUT));
  assign xfer_to  = (timer == TW'(XFER_TIMEOUT));

  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:       if (pick_vld && !busy_q) next_state = ISSUE;
      ISSUE:      next_state = WAIT_START;
      WAIT_START: begin
        if (busy_q)        next_state = WAIT_DONE;
        else if (start_to) next_state = RESP;
      end
      WAIT_DONE:  if (!busy_q || xfer_to) next_state = RESP;
      RESP:       next_state = IDLE;
      default:    next_state = IDLE;
    endcase
  end

  always_comb begin
    m_write_en = 1'b0;
    m_read_en  = 1'b0;
    rsp_valid  = '0;
    case (state)
      ISSUE: begin
        m_write_en = !cur_x.rw;
        m_read_en  = cur_x.rw;
      end
      RESP:    rsp_valid = gnt;
      default: ;
    endcase
  end

  assign m_chip_addr = cur_x.chip;
  assign m_reg_addr  = cur_x.regad;
  assign m_data_in   = cur_x.wdata;

  always_ff @(posedge clk) begin
    if (!reset) begin
      cur_x      <= '0;
      cur_idx    <= '0;
      gnt        <= '0;
      last_grant <= IW'(NUM_REQ - 1);
      timer      <= '0;
      rsp_rdata  <= 16'h0;
      rsp_status <= 4'h0;
    end else begin
      case (state)
        IDLE: begin
          timer <= '0;
          if (next_state == ISSUE) begin
            cur_x   <= pick_x;
            cur_idx <= pick;
            gnt     <= {{(NUM_REQ-1){1'b0}}, 1'b1} << pick;
          end
        end
        ISSUE: timer <= '0;
        WAIT_START: begin
          timer <= busy_q ? '0 : timer + 1'b1;
          if (!busy_q && start_to) begin
            rsp_status <= 4'hE;
            rsp_rdata  <= 16'h0;
          end
        end
        WAIT_DONE: begin
          timer <= timer + 1'b1;
          if (!busy_q) begin
            rsp_status <= status_q;
            rsp_rdata  <= cur_x.rw ? dout_q : 16'h0;
          end else if (xfer_to) begin
            rsp_status <= 4'hF;
            rsp_rdata  <= 16'h0;
          end
        end
        RESP: begin
          gnt        <= '0;
          last_grant <= cur_idx;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_master_arbiter.sv
// Directed bench for i2c_master_arbiter; the master side is played by
// bench tasks that drive busy/status/data and keep a small register file.
module tb_i2c_master_arbiter;
  localparam int NR = 4;
  localparam int ST = 64;
  localparam int XT = 65535;

  logic           clk;
  logic           reset;
  logic [NR-1:0]  req, req_rw;
  logic [7*NR-1:0]  req_chip_addr;
  logic [8*NR-1:0]  req_reg_addr;
  logic [16*NR-1:0] req_wdata;
  logic [NR-1:0]  gnt, rsp_valid;
  logic [15:0]    rsp_rdata;
  logic [3:0]     rsp_status;
  logic [6:0]     m_chip_addr;
  logic [7:0]     m_reg_addr;
  logic [15:0]    m_data_in;
  logic           m_write_en, m_read_en;
  logic           m_busy;
  logic [3:0]     m_status;
  logic [15:0]    m_data_out;

  logic [15:0] mem [0:255];
  int checks = 0;
  int errors = 0;

  i2c_master_arbiter #(.NUM_REQ(NR), .START_TIMEOUT(ST), .XFER_TIMEOUT(XT)) dut (
    .clk(clk), .reset(reset), .req(req), .req_rw(req_rw),
    .req_chip_addr(req_chip_addr), .req_reg_addr(req_reg_addr), .req_wdata(req_wdata),
    .gnt(gnt), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_status(rsp_status),
    .m_chip_addr(m_chip_addr), .m_reg_addr(m_reg_addr), .m_data_in(m_data_in),
    .m_write_en(m_write_en), .m_read_en(m_read_en), .m_busy(m_busy),
    .m_status(m_status), .m_data_out(m_data_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input logic [1:0] i, input logic rw, input logic [6:0] ca,
                         input logic [7:0] ra, input logic [15:0] wd);
    req_rw[i] = rw;
    req_chip_addr[7*i +: 7] = ca;
    req_reg_addr[8*i +: 8]  = ra;
    req_wdata[16*i +: 16]   = wd;
  endtask

  // Ticks until an enable pulse is seen; lat = -1 if none within the bound.
  task automatic wait_pulse(output int lat);
    lat = -1;
    for (int i = 1; i <= 10; i++) begin
      tick();
      if (m_write_en || m_read_en) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic wait_rsp(output int lat);
    lat = -1;
    for (int i = 1; i <= 4*ST; i++) begin
      tick();
      if (rsp_valid != '0) begin
        lat = i;
        break;
      end
    end
  endtask

  // Called in the issue-pulse cycle: act as the master for one transaction.
  task automatic slave(input int hold);
    logic [7:0]  ra;
    logic        wr;
    logic [15:0] wd;
    ra = m_reg_addr;
    wr = m_write_en;
    wd = m_data_in;
    tick();
    m_busy = 1'b1;
    repeat (hold) tick();
    if (wr) mem[ra] = wd;
    else    m_data_out = mem[ra];
    m_status = 4'h0;
    m_busy   = 1'b0;
  endtask

  initial begin
    int lat;
    int exp_ord [5];
    logic bad;
    exp_ord = '{0, 1, 2, 3, 0};
    for (int i = 0; i < 256; i++) mem[i] = 16'h0;
    reset = 1'b0; req = '0; req_rw = '0;
    req_chip_addr = '0; req_reg_addr = '0; req_wdata = '0;
    m_busy = 1'b0; m_status = 4'h0; m_data_out = 16'h0;

    // reset state
    repeat (2) tick();
    chk("rst_gnt",    32'(gnt), 32'h0);
    chk("rst_rspv",   32'(rsp_valid), 32'h0);
    chk("rst_en",     32'({m_write_en, m_read_en}), 32'h0);
    chk("rst_regad",  32'(m_reg_addr), 32'h0);
    chk("rst_status", 32'(rsp_status), 32'h0);
    reset = 1'b1;
    tick();

    // single write from requester 0
    set_req(2'd0, 1'b0, 7'h0F, 8'h0A, 16'hB2B2);
    req = 4'b0001;
    wait_pulse(lat);
    chk("wr_issue_lat", 32'(lat), 32'd1);
    chk("wr_en",        32'({m_write_en, m_read_en}), 32'b10);
    chk("wr_gnt",       32'(gnt), 32'b0001);
    chk("wr_chip",      32'(m_chip_addr), 32'h0F);
    chk("wr_data",      32'(m_data_in), 32'hB2B2);
    tick();
    chk("wr_pulse_once", 32'(m_write_en), 32'h0);
    m_busy = 1'b1;
    repeat (4) tick();
    chk("wr_reg_hold", 32'(m_reg_addr), 32'h0A);
    chk("wr_gnt_hold", 32'(gnt), 32'b0001);
    mem[m_reg_addr] = m_data_in;
    m_status = 4'h0;
    m_busy   = 1'b0;
    tick();
    chk("wr_rsp_early", 32'(rsp_valid), 32'h0);
    tick();
    chk("wr_rsp_valid",  32'(rsp_valid), 32'b0001);
    chk("wr_rsp_status", 32'(rsp_status), 32'h0);
    chk("wr_reg_resp",   32'(m_reg_addr), 32'h0A);
    req = '0;
    tick();
    chk("wr_rsp_single", 32'(rsp_valid), 32'h0);
    chk("wr_gnt_clear",  32'(gnt), 32'h0);
    chk("slave_reg_0a",  32'(mem[8'h0A]), 32'hB2B2);

    // single read from requester 2
    set_req(2'd2, 1'b1, 7'h0F, 8'h0A, 16'h0000);
    req = 4'b0100;
    wait_pulse(lat);
    chk("rd_en",  32'({m_write_en, m_read_en}), 32'b01);
    chk("rd_gnt", 32'(gnt), 32'b0100);
    slave(3);
    wait_rsp(lat);
    chk("rd_rsp_lat",   32'(lat), 32'd2);
    chk("rd_rsp_valid", 32'(rsp_valid), 32'b0100);
    chk("rd_rdata",     32'(rsp_rdata), 32'hB2B2);
    chk("rd_status",    32'(rsp_status), 32'h0);
    req = '0;
    tick();
    chk("rd_rdata_held", 32'(rsp_rdata), 32'hB2B2);

    // round robin with all requesters active, from a fresh last_grant
    reset = 1'b0;
    tick();
    reset = 1'b1;
    set_req(2'd0, 1'b0, 7'h0F, 8'h00, 16'hA1A1);
    set_req(2'd1, 1'b0, 7'h0F, 8'h0A, 16'hB2B2);
    set_req(2'd2, 1'b0, 7'h0F, 8'h10, 16'hC3C3);
    set_req(2'd3, 1'b0, 7'h0F, 8'h1A, 16'hD4D4);
    req = 4'b1111;
    for (int t = 0; t < 5; t++) begin
      wait_pulse(lat);
      chk($sformatf("rr_gnt%0d", t), 32'(gnt), 32'd1 << exp_ord[t]);
      chk($sformatf("rr_rd_en%0d", t), 32'(m_read_en), 32'h0);
      slave(2);
      wait_rsp(lat);
      chk($sformatf("rr_rsp%0d", t), 32'(rsp_valid), 32'd1 << exp_ord[t]);
    end
    req = '0;
    tick();
    chk("rr_mem00", 32'(mem[8'h00]), 32'hA1A1);
    chk("rr_mem10", 32'(mem[8'h10]), 32'hC3C3);
    chk("rr_mem1a", 32'(mem[8'h1A]), 32'hD4D4);

    // start timeout: master never raises busy
    set_req(2'd3, 1'b0, 7'h0F, 8'h20, 16'h1234);
    req = 4'b1000;
    wait_pulse(lat);
    chk("st_gnt", 32'(gnt), 32'b1000);
    req = '0;
    wait_rsp(lat);
    chk("st_lat",    32'(lat), 32'(ST + 2));
    chk("st_status", 32'(rsp_status), 32'hE);
    chk("st_rspv",   32'(rsp_valid), 32'b1000);
    tick();
    chk("st_idle_gnt", 32'(gnt), 32'h0);
    set_req(2'd1, 1'b0, 7'h0F, 8'h30, 16'h5A5A);
    req = 4'b0010;
    wait_pulse(lat);
    chk("st_next_gnt", 32'(gnt), 32'b0010);
    req = '0;
    slave(2);
    wait_rsp(lat);
    chk("st_next_rsp",    32'(rsp_valid), 32'b0010);
    chk("st_next_status", 32'(rsp_status), 32'h0);
    tick();
    chk("st_next_mem", 32'(mem[8'h30]), 32'h5A5A);

    // master busy while idle: nothing is granted until it releases
    m_busy = 1'b1;
    tick();
    set_req(2'd1, 1'b0, 7'h0F, 8'h40, 16'h0F0F);
    req = 4'b0010;
    bad = 1'b0;
    repeat (6) begin
      tick();
      if (gnt != '0 || m_write_en || m_read_en) bad = 1'b1;
    end
    chk("busy_idle_quiet", 32'(bad), 32'h0);
    m_busy = 1'b0;
    wait_pulse(lat);
    chk("busy_release_lat", 32'(lat >= 1 && lat <= 2), 32'h1);
    chk("busy_release_gnt", 32'(gnt), 32'b0010);
    req = '0;
    slave(2);
    wait_rsp(lat);
    chk("busy_rsp", 32'(rsp_valid), 32'b0010);
    tick();

    // reset during WAIT_DONE abandons the transaction
    set_req(2'd0, 1'b0, 7'h0F, 8'h50, 16'h7777);
    req = 4'b0001;
    wait_pulse(lat);
    req = '0;
    tick();
    m_busy = 1'b1;
    repeat (3) tick();
    chk("mid_gnt_pre", 32'(gnt), 32'b0001);
    reset = 1'b0;
    tick();
    reset  = 1'b1;
    m_busy = 1'b0;
    chk("mid_gnt",   32'(gnt), 32'h0);
    chk("mid_rspv",  32'(rsp_valid), 32'h0);
    chk("mid_en",    32'({m_write_en, m_read_en}), 32'h0);
    chk("mid_regad", 32'(m_reg_addr), 32'h0);
    chk("mid_chip",  32'(m_chip_addr), 32'h0);
    chk("mid_data",  32'(m_data_in), 32'h0);
    set_req(2'd1, 1'b0, 7'h0F, 8'h60, 16'h1111);
    set_req(2'd3, 1'b0, 7'h0F, 8'h70, 16'h3333);
    req = 4'b1010;
    wait_pulse(lat);
    chk("mid_after_lat",  32'(lat), 32'd1);
    chk("mid_after_gnt",  32'(gnt), 32'b0010);
    chk("mid_after_rspv", 32'(rsp_valid), 32'h0);
    req = '0;
    slave(2);
    wait_rsp(lat);
    chk("mid_after_rsp", 32'(rsp_valid), 32'b0010);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
